pipelined_adder: RTL and testbench

Parametrised, pipelined add/subtract unit with a valid/ready stream interface. It is the sequential successor to the team's single-cycle half-adder, full-adder and ripple-carry adder primitives. Operands are split into STAGES equal slices, and one slice is resolved per clock with a registered carry between stages, so WIDTH can grow without lengthening the critical path. It sits between operand-producing logic and any consumer that can apply backpressure.

---
 rtl/pipelined_adder.sv | 154 +++++++++++++++
 tb/tb_pipelined_adder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// -----------------------------------------------------------------------------
// pipelined_adder
//
// Pipelined add/subtract unit with a valid/ready stream interface. The
// operands are cut into STAGES slices of SW = WIDTH/STAGES bits. Stage k
// resolves slice k, and a registered carry links each stage to the next, so
// the critical path is one SW-bit adder no matter how wide WIDTH grows.
//
// Skew: every stage carries the full A and effective-B words forward, so the
//   upper slices are still present when their stage is reached.
// Deskew: every stage also carries the partial sum, so the lower result
//   slices arrive aligned with the top slice at the last stage.
//
// The pipeline stalls globally. When the output holds a result that the
// consumer is not taking, every stage holds, and in_ready drops.
//
// Parameters
//   WIDTH   operand/result width; must be a multiple of STAGES, >= 2
//   STAGES  pipeline depth and slice count, 1 <= STAGES <= WIDTH
//
// Ports
//   clk        clock; all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand beat offered
//   in_ready   beat accepted this cycle (= !out_valid || out_ready)
//   a, b       operands (two's complement or unsigned)
//   cin        carry-in for add / borrow-in for subtract
//   sub        0: a + b + cin, 1: a - b - cin
//   out_valid  result beat present
//   out_ready  consumer takes the result this cycle
//   sum        result modulo 2^WIDTH (0 when out_valid = 0)
//   cout       carry-out for add / NOT-borrow for subtract (0 when idle)
//   ovf        signed overflow (0 when idle)
// -----------------------------------------------------------------------------
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SW = WIDTH / STAGES;

    // Per-stage inputs. Stage 0 takes them from the ports, and stage k takes
    // them from the registers of stage k-1.
    logic [WIDTH-1:0] w_ain [STAGES];
    logic [WIDTH-1:0] w_bin [STAGES];
    logic [WIDTH-1:0] w_sin [STAGES];
    logic             w_cin [STAGES];
    logic             w_vin [STAGES];

    // Per-stage registers
    logic [WIDTH-1:0] r_a [STAGES];   // operand A (skew)
    logic [WIDTH-1:0] r_b [STAGES];   // effective operand B (skew)
    logic [WIDTH-1:0] r_s [STAGES];   // partial sum, slices 0..k (deskew)
    logic             r_c [STAGES];   // carry out of slice k
    logic             r_v [STAGES];   // stage holds a real beat
    logic             r_ovf;          // overflow flag, last stage only

    logic w_advance;
    logic w_ovf_next;

    // One global enable. A stalled output freezes the whole pipe, so no
    // per-stage skid buffering is needed.
    assign w_advance = !r_v[STAGES-1] || out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SW:0]      w_slice;
        logic [WIDTH-1:0] w_snext;

        if (k == 0) begin : g_first
            // Subtract is a + ~b + !cin. The inversion happens once, at entry.
            assign w_ain[k] = a;
            assign w_bin[k] = b ^ {WIDTH{sub}};
            assign w_sin[k] = '0;
            assign w_cin[k] = cin ^ sub;
            assign w_vin[k] = in_valid;
        end else begin : g_next
            assign w_ain[k] = r_a[k-1];
            assign w_bin[k] = r_b[k-1];
            assign w_sin[k] = r_s[k-1];
            assign w_cin[k] = r_c[k-1];
            assign w_vin[k] = r_v[k-1];
        end

        assign w_slice = {1'b0, w_ain[k][k*SW +: SW]}
                       + {1'b0, w_bin[k][k*SW +: SW]}
                       + {{SW{1'b0}}, w_cin[k]};

        always_comb begin
            w_snext               = w_sin[k];
            w_snext[k*SW +: SW]   = w_slice[SW-1:0];
        end

        if (k == STAGES - 1) begin : g_ovf
            // The carry into the MSB is recovered as a ^ b ^ sum at that bit.
            // XORing it with the carry out gives signed overflow.
            assign w_ovf_next = w_ain[k][WIDTH-1] ^ w_bin[k][WIDTH-1]
                              ^ w_slice[SW-1] ^ w_slice[SW];
        end

        // NOTE: the data registers are reset as well as the valid bits. This
        // gives a deterministic post-reset state and keeps the X-free output
        // gating independent of what the pipe held before reset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v[k] <= 1'b0;
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
                r_c[k] <= 1'b0;
            end else if (w_advance) begin
                // NOTE: non-blocking assignments, so each stage samples the
                // previous stage's value from before this edge.
                r_v[k] <= w_vin[k];
                if (w_vin[k]) begin
                    r_a[k] <= w_ain[k];
                    r_b[k] <= w_bin[k];
                    r_s[k] <= w_snext;
                    r_c[k] <= w_slice[SW];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_advance && w_vin[STAGES-1]) begin
            r_ovf <= w_ovf_next;
        end
    end

    assign in_ready  = w_advance;
    assign out_valid = r_v[STAGES-1];

    // Gate the outputs so an idle pipe never shows stale or garbage data
    assign sum  = r_v[STAGES-1] ? r_s[STAGES-1] : '0;
    assign cout = r_v[STAGES-1] & r_c[STAGES-1];
    assign ovf  = r_v[STAGES-1] & r_ovf;

endmodule

// File: tb/tb_pipelined_adder.sv
// -----------------------------------------------------------------------------
// tb_pipelined_adder
//
// Directed and stream checks for pipelined_adder. There is a WIDTH=16,
// STAGES=4 instance with backpressure, plus STAGES=1 and STAGES=16 instances
// that share the input stimulus and hold out_ready at 1.
// -----------------------------------------------------------------------------
module tb_pipelined_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_ready;
    logic        aux_ready;

    logic        m_in_ready, m_out_valid, m_cout, m_ovf;
    logic [15:0] m_sum;
    logic        s1_in_ready, s1_out_valid, s1_cout, s1_ovf;
    logic [15:0] s1_sum;
    logic        s16_in_ready, s16_out_valid, s16_cout, s16_ovf;
    logic [15:0] s16_sum;

    int checks   = 0;
    int failures = 0;

    pipelined_adder #(.WIDTH(16), .STAGES(4)) u_main (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(m_in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(m_out_valid),
        .out_ready(out_ready), .sum(m_sum), .cout(m_cout), .ovf(m_ovf)
    );

    pipelined_adder #(.WIDTH(16), .STAGES(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s1_in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(s1_out_valid),
        .out_ready(aux_ready), .sum(s1_sum), .cout(s1_cout), .ovf(s1_ovf)
    );

    pipelined_adder #(.WIDTH(16), .STAGES(16)) u_s16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s16_in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(s16_out_valid),
        .out_ready(aux_ready), .sum(s16_sum), .cout(s16_cout), .ovf(s16_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Flat reference: {valid, cout, ovf, sum}. The carry into the MSB comes
    // from a separate narrower add.
    function automatic logic [18:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic ci, input logic s);
        logic [15:0] be;
        logic        c0;
        logic [16:0] full;
        logic [15:0] low;
        be   = s ? ~y : y;
        c0   = s ? ~ci : ci;
        full = {1'b0, x} + {1'b0, be} + {16'b0, c0};
        low  = {1'b0, x[14:0]} + {1'b0, be[14:0]} + {15'b0, c0};
        return {1'b1, full[16], low[15] ^ full[16], full[15:0]};
    endfunction

    function automatic logic [18:0] m_obs();
        return {m_out_valid, m_cout, m_ovf, m_sum};
    endfunction

    // One isolated beat on the STAGES=4 instance. Checks latency, the result,
    // and that the outputs return to zero once the result is consumed.
    task automatic directed(input string tag, input logic [15:0] x, input logic [15:0] y,
                            input logic ci, input logic s,
                            input logic [15:0] es, input logic ec, input logic eo);
        int lat;
        @(negedge clk);
        a = x; b = y; cin = ci; sub = s; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!m_out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, 4);
        check({tag, "_result"}, m_obs(), {1'b1, ec, eo, es});
        @(negedge clk);
        check({tag, "_drained"}, m_obs(), 0);
    endtask

    logic [18:0] hist [200];

    function automatic logic [18:0] exp_at(input int stages, input int i);
        int j;
        j = i - stages;
        if (j >= 0 && j < 200) return hist[j];
        return 19'd0;
    endfunction

    initial begin
        logic [15:0] sa, sb;
        logic        sc, ss;
        logic        pending;
        logic        prev_stall;
        logic [18:0] prev_out;
        logic [18:0] expv;
        logic [18:0] q [$];
        int          n_sent, n_rcv;

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        out_ready = 1'b0; aux_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_outputs", m_obs(), 0);
        check("reset_in_ready", m_in_ready, 1);
        rst_n = 1'b1;

        // Directed vectors
        directed("add_ffff_1",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        directed("add_7fff_1",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        directed("add_cin",     16'h1234, 16'h0000, 1'b1, 1'b0, 16'h1235, 1'b0, 1'b0);
        directed("sub_5_7",     16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        directed("sub_8000_1",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        directed("sub_borrowin",16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0);

        // Stream of 8 random beats with out_ready cycling 1,0,0
        pending = 1'b0; prev_stall = 1'b0; prev_out = '0;
        n_sent = 0; n_rcv = 0;
        sa = '0; sb = '0; sc = 1'b0; ss = 1'b0;
        for (int cyc = 0; cyc < 300 && n_rcv < 8; cyc++) begin
            @(negedge clk);
            if (prev_stall) check("stall_hold", m_obs(), prev_out);
            out_ready = (cyc % 3 == 0);
            if (!pending && n_sent < 8) begin
                sa = 16'($urandom); sb = 16'($urandom);
                sc = 1'($urandom);  ss = 1'($urandom);
                pending = 1'b1;
            end
            in_valid = pending; a = sa; b = sb; cin = sc; sub = ss;
            #1;
            check("stream_in_ready", m_in_ready, !m_out_valid || out_ready);
            if (in_valid && m_in_ready) begin
                q.push_back(model(sa, sb, sc, ss));
                pending = 1'b0;
                n_sent++;
            end
            if (m_out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("stream_extra_beat", 1, 0);
                end else begin
                    expv = q.pop_front();
                    check("stream_result", m_obs(), expv);
                end
                n_rcv++;
            end
            prev_stall = m_out_valid && !out_ready;
            prev_out   = m_obs();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("stream_count", n_rcv, 8);
        repeat (5) @(negedge clk);
        check("stream_no_dup", m_obs(), 0);

        // Fill the pipe while the output stalls, then pulse reset mid-cycle
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 16'h1000 + 16'(i); b = 16'h0001; cin = 1'b0; sub = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("prefill_valid", m_out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_outputs", m_obs(), 0);
        check("rst_async_in_ready", m_in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rst_flushed", m_obs(), 0);
        end
        directed("post_reset", 16'h0102, 16'h0304, 1'b0, 1'b0, 16'h0406, 1'b0, 1'b0);

        // 200 back-to-back random beats, checked on all three depths
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 218; i++) begin
            @(negedge clk);
            check("rand_s4",  {m_out_valid, m_cout, m_ovf, m_sum}, exp_at(4, i));
            check("rand_s1",  {s1_out_valid, s1_cout, s1_ovf, s1_sum}, exp_at(1, i));
            check("rand_s16", {s16_out_valid, s16_cout, s16_ovf, s16_sum}, exp_at(16, i));
            if (i < 200) begin
                sa = 16'($urandom); sb = 16'($urandom);
                sc = 1'($urandom);  ss = 1'($urandom);
                hist[i] = model(sa, sb, sc, ss);
                in_valid = 1'b1; a = sa; b = sb; cin = sc; sub = ss;
            end else begin
                in_valid = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
